can_crc_rx_seq: RTL and testbench

Receive-side CRC sequencer for the CAN controller. It consumes the destuffed, sampled bit stream of a standard (11-bit ID) CAN frame and tracks the frame fields. It drives a 15-bit CAN CRC step unit over SOF through the end of the data field, then shifts in the transmitted CRC field and compares it. It sits between the bit-timing/destuff logic and the frame assembler, and reports CRC pass/fail and form errors.

---
 rtl/can_pkg.sv | 17 +
 rtl/can_crc15_step.sv | 36 +++
 rtl/can_crc_rx_seq.sv | 157 +++++++++++++++
 tb/tb_can_crc_rx_seq.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/can_pkg.sv
// Shared types and field-length constants for the CAN receive CRC path.
package can_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    CTRL,
    DATA,
    CRCF,
    CDEL
  } crc_seq_state_t;

  localparam int unsigned CAN_CRC_W     = 15;
  localparam int unsigned CAN_ARB_BITS  = 12;
  localparam int unsigned CAN_CTRL_BITS = 6;

endpackage

// File: rtl/can_crc15_step.sv
// CAN CRC-15 polynomial register: optional clear, then one serial step per enabled bit.
module can_crc15_step
  import can_pkg::*;
#(
  parameter logic [CAN_CRC_W-1:0] POLY = 15'h4599
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 step,
  input  logic                 bit_in,
  output logic [CAN_CRC_W-1:0] crc
);

  logic [CAN_CRC_W-1:0] crc_q, crc_d, base;

  // Clear and step in the same cycle seeds the register from zero (used for SOF).
  always_comb begin
    base  = clear ? '0 : crc_q;
    crc_d = crc_q;
    if (step) begin
      if (base[CAN_CRC_W-1] ^ bit_in) crc_d = {base[CAN_CRC_W-2:0], 1'b0} ^ POLY;
      else                            crc_d = {base[CAN_CRC_W-2:0], 1'b0};
    end else if (clear) begin
      crc_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) crc_q <= '0;
    else     crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/can_crc_rx_seq.sv
// Receive-side CAN CRC sequencer: tracks standard-frame fields, drives the CRC-15
// register over SOF..data, then captures and compares the transmitted CRC field.
module can_crc_rx_seq
  import can_pkg::*;
#(
  parameter logic [CAN_CRC_W-1:0] POLY      = 15'h4599,
  parameter int unsigned          MAX_BYTES = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bit_valid,
  input  logic                 rx_bit,
  input  logic                 abort,
  output logic                 busy,
  output logic                 crc_ok,
  output logic                 crc_err,
  output logic                 form_err,
  output logic [CAN_CRC_W-1:0] crc_calc,
  output logic [3:0]           dlc
);

  localparam logic [3:0] MAX_B = 4'(MAX_BYTES);

  crc_seq_state_t       state_q, state_d;
  logic [6:0]           cnt_q, cnt_d;
  logic                 rtr_q, rtr_d;
  logic [3:0]           dlc_q, dlc_d;
  logic [2:0]           dlc_part_q, dlc_part_d;
  logic [CAN_CRC_W-1:0] rxcrc_q, rxcrc_d;
  logic                 ok_q, ok_d, err_q, err_d, ferr_q, ferr_d;
  logic                 crc_clear, crc_step;
  logic [3:0]           dlc_full, data_bytes;
  logic [6:0]           data_bits;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rtr_d      = rtr_q;
    dlc_d      = dlc_q;
    dlc_part_d = dlc_part_q;
    rxcrc_d    = rxcrc_q;
    ok_d       = 1'b0;
    err_d      = 1'b0;
    ferr_d     = 1'b0;
    crc_clear  = 1'b0;
    crc_step   = 1'b0;
    dlc_full   = {dlc_part_q, rx_bit};
    data_bytes = (dlc_full > MAX_B) ? MAX_B : dlc_full;
    data_bits  = rtr_q ? '0 : {data_bytes, 3'b000};

    if (abort) begin
      state_d = IDLE;
    end else if (bit_valid) begin
      unique case (state_q)
        IDLE: begin
          if (!rx_bit) begin
            crc_clear = 1'b1;
            crc_step  = 1'b1;
            cnt_d     = '0;
            state_d   = ARB;
          end
        end
        ARB: begin
          crc_step = 1'b1;
          cnt_d    = cnt_q + 7'd1;
          if (cnt_q == 7'(CAN_ARB_BITS - 1)) begin
            rtr_d   = rx_bit;
            cnt_d   = '0;
            state_d = CTRL;
          end
        end
        CTRL: begin
          crc_step = 1'b1;
          cnt_d    = cnt_q + 7'd1;
          if (cnt_q == 7'd0 && rx_bit) begin
            ferr_d  = 1'b1;
            state_d = IDLE;
          end else if (cnt_q == 7'(CAN_CTRL_BITS - 1)) begin
            dlc_d = dlc_full;
            if (data_bits == '0) begin
              cnt_d   = '0;
              state_d = CRCF;
            end else begin
              cnt_d   = data_bits;
              state_d = DATA;
            end
          end else if (cnt_q >= 7'd2) begin
            dlc_part_d = {dlc_part_q[1:0], rx_bit};
          end
        end
        DATA: begin
          crc_step = 1'b1;
          cnt_d    = cnt_q - 7'd1;
          if (cnt_q == 7'd1) begin
            cnt_d   = '0;
            state_d = CRCF;
          end
        end
        CRCF: begin
          rxcrc_d = {rxcrc_q[CAN_CRC_W-2:0], rx_bit};
          cnt_d   = cnt_q + 7'd1;
          if (cnt_q == 7'(CAN_CRC_W - 1)) begin
            cnt_d   = '0;
            state_d = CDEL;
          end
        end
        CDEL: begin
          if (!rx_bit)                  ferr_d = 1'b1;
          else if (rxcrc_q == crc_calc) ok_d   = 1'b1;
          else                          err_d  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rtr_q      <= 1'b0;
      dlc_q      <= '0;
      dlc_part_q <= '0;
      rxcrc_q    <= '0;
      ok_q       <= 1'b0;
      err_q      <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rtr_q      <= rtr_d;
      dlc_q      <= dlc_d;
      dlc_part_q <= dlc_part_d;
      rxcrc_q    <= rxcrc_d;
      ok_q       <= ok_d;
      err_q      <= err_d;
      ferr_q     <= ferr_d;
    end
  end

  can_crc15_step #(.POLY(POLY)) u_crc (
    .clk    (clk),
    .rst    (rst),
    .clear  (crc_clear),
    .step   (crc_step),
    .bit_in (rx_bit),
    .crc    (crc_calc)
  );

  assign busy     = (state_q != IDLE);
  assign crc_ok   = ok_q;
  assign crc_err  = err_q;
  assign form_err = ferr_q;
  assign dlc      = dlc_q;

endmodule

// File: tb/tb_can_crc_rx_seq.sv
// Directed bench for can_crc_rx_seq with hand-computed CRC-15 values.
module tb_can_crc_rx_seq;

  logic        clk = 1'b0;
  logic        rst, bit_valid, rx_bit, abort;
  logic        busy, crc_ok, crc_err, form_err;
  logic [14:0] crc_calc;
  logic [3:0]  dlc;

  int unsigned errors = 0, checks = 0;
  int unsigned n_ok = 0, n_err = 0, n_ferr = 0;
  logic        ok_now, err_now, ferr_now;

  can_crc_rx_seq #(.POLY(15'h4599), .MAX_BYTES(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .bit_valid(bit_valid),
    .rx_bit   (rx_bit),
    .abort    (abort),
    .busy     (busy),
    .crc_ok   (crc_ok),
    .crc_err  (crc_err),
    .form_err (form_err),
    .crc_calc (crc_calc),
    .dlc      (dlc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned total();
    return n_ok + n_err + n_ferr;
  endfunction

  task automatic sample();
    ok_now   = crc_ok;
    err_now  = crc_err;
    ferr_now = form_err;
    n_ok   += 32'(crc_ok);
    n_err  += 32'(crc_err);
    n_ferr += 32'(form_err);
  endtask

  task automatic send_bit(input logic b);
    bit_valid = 1'b1;
    rx_bit    = b;
    @(posedge clk);
    #1;
    bit_valid = 1'b0;
    sample();
  endtask

  task automatic send_field(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_hdr(input logic [10:0] id, input logic rtr, input logic [3:0] dl);
    send_bit(1'b0);
    send_field(64'(id), 11);
    send_bit(rtr);
    send_bit(1'b0);
    send_bit(1'b0);
    send_field(64'(dl), 4);
  endtask

  task automatic do_abort(input logic with_bit);
    abort     = 1'b1;
    bit_valid = with_bit;
    rx_bit    = 1'b0;
    @(posedge clk);
    #1;
    abort     = 1'b0;
    bit_valid = 1'b0;
    sample();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned p;
    int k;
    rst = 1'b1; bit_valid = 1'b0; rx_bit = 1'b1; abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_crc", crc_calc, 0);
    check("rst_dlc", dlc, 0);
    check("rst_pulses", {crc_ok, crc_err, form_err}, 3'b000);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // All-zero frame, CRC field 0
    p = total();
    send_hdr(11'h000, 1'b0, 4'h0);
    check("zero_busy", busy, 1);
    check("zero_crc", crc_calc, 15'h0000);
    send_field(64'h0, 15);
    send_bit(1'b1);
    check("zero_ok", {ok_now, err_now, ferr_now}, 3'b100);
    check("zero_busy_end", busy, 0);
    check("zero_npulse", total() - p, 1);

    // Same frame, wrong CRC field
    send_hdr(11'h000, 1'b0, 4'h0);
    send_field(64'h1, 15);
    send_bit(1'b1);
    check("badcrc_err", {ok_now, err_now, ferr_now}, 3'b010);

    // ID = 1, DLC 0 -> CRC 0x2213
    send_hdr(11'h001, 1'b0, 4'h0);
    check("id1_crc", crc_calc, 15'h2213);
    send_field(64'h2213, 15);
    check("id1_frozen", crc_calc, 15'h2213);
    check("id1_busy", busy, 1);
    send_bit(1'b1);
    check("id1_ok", {ok_now, err_now, ferr_now}, 3'b100);

    // RTR = 1, DLC 3 -> no data bits, CRC 0x78F7
    p = total();
    send_hdr(11'h000, 1'b1, 4'h3);
    check("rtr_crc", crc_calc, 15'h78F7);
    check("rtr_dlc", dlc, 4'h3);
    send_field(64'h78F7, 15);
    check("rtr_busy_cdel", busy, 1);
    check("rtr_nopulse", total() - p, 0);
    send_bit(1'b1);
    check("rtr_ok", {ok_now, err_now, ferr_now}, 3'b100);

    // DLC = F clamps to 64 data bits; result must land on bit 16 after the data
    p = total();
    send_hdr(11'h000, 1'b0, 4'hF);
    check("dlcF_dlc", dlc, 4'hF);
    send_field(64'h0, 64);
    check("dlcF_busy", busy, 1);
    k = 0;
    while (total() == p && k < 40) begin
      send_bit(1'b1);
      k++;
    end
    check("dlcF_len", k, 16);
    check("dlcF_noform", ferr_now, 0);
    check("dlcF_busy_end", busy, 0);

    // IDE = 1 -> form error on the IDE bit, next SOF accepted immediately
    send_bit(1'b0);
    send_field(64'h0, 11);
    send_bit(1'b0);
    send_bit(1'b1);
    check("ide_form", {ok_now, err_now, ferr_now}, 3'b001);
    check("ide_busy", busy, 0);
    send_bit(1'b0);
    check("ide_next_sof", busy, 1);
    do_abort(1'b0);
    check("ide_abort_busy", busy, 0);

    // Valid CRC, delimiter 0
    send_hdr(11'h000, 1'b0, 4'h0);
    send_field(64'h0, 15);
    send_bit(1'b0);
    check("delim0_form", {ok_now, err_now, ferr_now}, 3'b001);
    check("delim0_busy", busy, 0);

    // Abort in DATA, then abort coincident with a bit
    p = total();
    send_hdr(11'h000, 1'b0, 4'h1);
    send_field(64'h0, 2);
    check("abort_pre_crc", crc_calc, 15'h58CF);
    do_abort(1'b0);
    check("abort_busy", busy, 0);
    check("abort_keep_crc", crc_calc, 15'h58CF);
    send_bit(1'b1);
    check("idle_recessive", busy, 0);
    send_hdr(11'h000, 1'b0, 4'h1);
    send_field(64'h0, 3);
    check("coinc_pre_crc", crc_calc, 15'h7407);
    do_abort(1'b1);
    check("coinc_busy", busy, 0);
    check("coinc_crc", crc_calc, 15'h7407);
    check("abort_nopulse", total() - p, 0);

    // Asynchronous reset mid-CRCF
    send_hdr(11'h000, 1'b1, 4'h3);
    send_field(64'h0F, 5);
    check("rstmid_busy_pre", busy, 1);
    check("rstmid_dlc_pre", dlc, 4'h3);
    #2 rst = 1'b1;
    #1;
    check("rstmid_busy", busy, 0);
    check("rstmid_crc", crc_calc, 0);
    check("rstmid_dlc", dlc, 0);
    check("rstmid_pulses", {crc_ok, crc_err, form_err}, 3'b000);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    send_hdr(11'h001, 1'b0, 4'h0);
    send_field(64'h2213, 15);
    send_bit(1'b1);
    check("recover_ok", {ok_now, err_now, ferr_now}, 3'b100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
